simon_sequencer: RTL and testbench

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_simon_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// ============================================================================
// Module   : simon_sequencer
// Purpose  : Simon memory game sequencer: grows an LFSR-drawn button sequence,
//            plays it back, then checks the player's answers one by one.
// Options  : define SIMON_TIMEOUT_EN to end the game after TIMEOUT_TICKS idle
//            cycles while waiting for a press.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_sequencer #(
  parameter int          MAX_LEN       = 16,
  parameter int          ON_TICKS      = 30,
  parameter int          OFF_TICKS     = 30,
  parameter int          TIMEOUT_TICKS = 300,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] player_num,
  input  logic       player_pressed,
  output logic       simon_turn,
  output logic [1:0] simon_num,
  output logic       simon_pressed,
  output logic [4:0] round,
  output logic       game_over,
  output logic       win
);

  localparam int TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_ADD          = 4'd1,
    S_PLAY_ON      = 4'd2,
    S_PLAY_OFF     = 4'd3,
    S_WAIT_PRESS   = 4'd4,
    S_WAIT_RELEASE = 4'd5,
    S_CHECK        = 4'd6,
    S_OVER         = 4'd7,
    S_WIN          = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    round_q, round_d;
  logic [4:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cap_q, cap_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          pressed_q;
  logic          turn_q, spressed_q, over_q, win_q;
  logic [1:0]    snum_q, snum_d;
  logic          wr_en;
  logic [1:0]    seq_q [MAX_LEN];

  function automatic logic [1:0] seq_at(input logic [4:0] i);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (i == 5'(k)) r = seq_q[k];
    end
    return r;
  endfunction

  // Sequence store is never reset; round bounds which entries are meaningful.
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_seq
    always_ff @(posedge clk) begin
      if (wr_en && round_q == 5'(g)) seq_q[g] <= lfsr_q[1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    cap_d   = cap_q;
    wr_en   = 1'b0;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          round_d = 5'd0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        wr_en   = 1'b1;
        round_d = round_q + 5'd1;
        idx_d   = 5'd0;
        timer_d = '0;
        state_d = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (timer_q == TW'(ON_TICKS - 1)) begin
          timer_d = '0;
          state_d = S_PLAY_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PLAY_OFF: begin
        if (timer_q == TW'(OFF_TICKS - 1)) begin
          timer_d = '0;
          if (idx_q < round_q - 5'd1) begin
            idx_d   = idx_q + 5'd1;
            state_d = S_PLAY_ON;
          end else begin
            idx_d   = 5'd0;
            state_d = S_WAIT_PRESS;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_PRESS: begin
        // Only a fresh rising press counts, so a button held over from playback is ignored.
        if (player_pressed && !pressed_q) begin
          cap_d   = player_num;
          timer_d = '0;
          state_d = S_WAIT_RELEASE;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
          timer_d = '0;
          state_d = S_OVER;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      S_WAIT_RELEASE: begin
        if (!player_pressed) state_d = S_CHECK;
      end
      S_CHECK: begin
        timer_d = '0;
        if (cap_q != seq_at(idx_q)) begin
          state_d = S_OVER;
        end else if (idx_q < round_q - 5'd1) begin
          idx_d   = idx_q + 5'd1;
          state_d = S_WAIT_PRESS;
        end else if (round_q < 5'(MAX_LEN)) begin
          state_d = S_ADD;
        end else begin
          state_d = S_WIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Playback index forwarding covers the element written in the same ADD cycle.
  always_comb begin
    snum_d = 2'd0;
    if (state_d == S_PLAY_ON || state_d == S_PLAY_OFF) begin
      if (wr_en && round_q == idx_d) snum_d = lfsr_q[1:0];
      else                           snum_d = seq_at(idx_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      round_q    <= 5'd0;
      idx_q      <= 5'd0;
      timer_q    <= '0;
      cap_q      <= 2'd0;
      lfsr_q     <= SEED;
      pressed_q  <= 1'b0;
      turn_q     <= 1'b0;
      spressed_q <= 1'b0;
      snum_q     <= 2'd0;
      over_q     <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      cap_q      <= cap_d;
      lfsr_q     <= lfsr_d;
      pressed_q  <= player_pressed;
      turn_q     <= (state_d == S_ADD) || (state_d == S_PLAY_ON) || (state_d == S_PLAY_OFF);
      spressed_q <= (state_d == S_PLAY_ON);
      snum_q     <= snum_d;
      over_q     <= (state_d == S_OVER);
      win_q      <= (state_d == S_WIN);
    end
  end

  assign simon_turn    = turn_q;
  assign simon_num     = snum_q;
  assign simon_pressed = spressed_q;
  assign round         = round_q;
  assign game_over     = over_q;
  assign win           = win_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_sequencer.sv
// ============================================================================
// Module   : tb_simon_sequencer
// Purpose  : Self-checking bench for simon_sequencer using a transaction-level
//            model of the game (sequence queue plus spec LFSR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_sequencer;

  localparam int         MAX_LEN       = 4;
  localparam int         ON_TICKS      = 3;
  localparam int         OFF_TICKS     = 2;
  localparam int         TIMEOUT_TICKS = 10;
  localparam logic [7:0] SEED          = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] player_num;
  logic       player_pressed;
  logic       simon_turn;
  logic [1:0] simon_num;
  logic       simon_pressed;
  logic [4:0] round;
  logic       game_over;
  logic       win;

  simon_sequencer #(
    .MAX_LEN(MAX_LEN), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .player_num(player_num),
    .player_pressed(player_pressed), .simon_turn(simon_turn), .simon_num(simon_num),
    .simon_pressed(simon_pressed), .round(round), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_seq[$];

  // Free-running generator as the game rules define it: steps every cycle from SEED.
  logic [7:0] lfsr_m;
  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_m <= SEED;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for the ADD cycle, then checks the full playback of the grown sequence.
  task automatic watch_playback();
    int waited = 0;
    while (!simon_turn && waited < 50) begin
      tick();
      waited++;
    end
    check("turn_rise", int'(simon_turn), 1);
    if (!simon_turn) return;
    check("add_dark", int'(simon_pressed), 0);
    check("round_at_add", int'(round), exp_seq.size());
    exp_seq.push_back(lfsr_m[1:0]);
    for (int i = 0; i < exp_seq.size(); i++) begin
      repeat (ON_TICKS) begin
        tick();
        player_num = 2'($urandom);
        check("on_pressed", int'(simon_pressed), 1);
        check("on_num", int'(simon_num), int'(exp_seq[i]));
        check("on_turn", int'(simon_turn), 1);
      end
      repeat (OFF_TICKS) begin
        tick();
        check("off_pressed", int'(simon_pressed), 0);
        check("off_turn", int'(simon_turn), 1);
      end
    end
    tick();
    check("end_turn", int'(simon_turn), 0);
    check("end_num", int'(simon_num), 0);
    check("end_round", int'(round), exp_seq.size());
  endtask

  // Press, hold with a jittering index, release; returns in the CHECK cycle.
  task automatic press(input logic [1:0] v);
    int hold;
    hold = $urandom_range(1, 3);
    player_num     = v;
    player_pressed = 1'b1;
    repeat (hold) begin
      tick();
      check("hold_turn", int'(simon_turn), 0);
      player_num = 2'($urandom);
    end
    player_pressed = 1'b0;
    tick();
  endtask

  task automatic answer_round(input int wrong_at);
    logic [1:0] v;
    logic [1:0] d;
    for (int i = 0; i < exp_seq.size(); i++) begin
      repeat ($urandom_range(0, 3)) begin
        player_num = 2'($urandom);
        tick();
      end
      d = 2'($urandom_range(1, 3));
      v = (i == wrong_at) ? (exp_seq[i] ^ d) : exp_seq[i];
      press(v);
      tick();
      if (i == wrong_at) return;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; player_pressed = 1'b0; player_num = 2'd0;
    #1;
    check("rst_turn", int'(simon_turn), 0);
    check("rst_num", int'(simon_num), 0);
    check("rst_pressed", int'(simon_pressed), 0);
    check("rst_round", int'(round), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_win", int'(win), 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    check("idle_turn", int'(simon_turn), 0);
    check("idle_round", int'(round), 0);

    // Full game to a win.
    start_game();
    check("start_over", int'(game_over), 0);
    exp_seq.delete();
    for (int r = 1; r <= MAX_LEN; r++) begin
      watch_playback();
      answer_round(-1);
    end
    check("win_flag", int'(win), 1);
    check("win_round", int'(round), MAX_LEN);
    check("win_turn", int'(simon_turn), 0);
    check("win_over", int'(game_over), 0);
    repeat (5) tick();
    check("win_held", int'(win), 1);

    // Restart, fail at index 1 of round 2.
    start_game();
    check("restart_win", int'(win), 0);
    check("restart_round", int'(round), 0);
    exp_seq.delete();
    watch_playback();
    answer_round(-1);
    watch_playback();
    answer_round(1);
    check("over_flag", int'(game_over), 1);
    check("over_round", int'(round), 2);
    check("over_turn", int'(simon_turn), 0);
    press(exp_seq[0]);
    repeat (5) tick();
    check("over_held", int'(game_over), 1);
    check("over_turn2", int'(simon_turn), 0);
    check("over_round2", int'(round), 2);
    start_game();
    check("restart_over", int'(game_over), 0);
    exp_seq.delete();
    watch_playback();

`ifdef SIMON_TIMEOUT_EN
    repeat (TIMEOUT_TICKS - 1) tick();
    check("to_early", int'(game_over), 0);
    tick();
    check("to_fire", int'(game_over), 1);
`else
    repeat (1000) tick();
    check("no_to_over", int'(game_over), 0);
    check("no_to_turn", int'(simon_turn), 0);
`endif

    // Asynchronous reset in the middle of playback.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_seq.delete();
    start_game();
    tick();
    tick();
    #2;
    reset = 1'b0;
    player_pressed = 1'b1;
    #1;
    check("arst_turn", int'(simon_turn), 0);
    check("arst_num", int'(simon_num), 0);
    check("arst_pressed", int'(simon_pressed), 0);
    check("arst_round", int'(round), 0);
    check("arst_over", int'(game_over), 0);
    check("arst_win", int'(win), 0);
    tick();
    reset = 1'b1;
    start_game();
    watch_playback();

    // A press held through playback must not count as an answer.
    player_num = exp_seq[0] ^ 2'd1;
    repeat (5) begin
      tick();
      check("held_turn", int'(simon_turn), 0);
      check("held_over", int'(game_over), 0);
    end
    player_pressed = 1'b0;
    tick();
    tick();
    check("held_release_over", int'(game_over), 0);
    answer_round(-1);
    watch_playback();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
